// File: rtl/stepper_ramp_axis.sv
// Single-axis stepper controller: relative moves with linear accel/cruise/decel period ramp.
// Optional STEPPER_LIMIT_EN adds synchronised active-low end-of-travel limit inputs.
module stepper_ramp_axis #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STEPS_W   = 24,
  parameter int unsigned POS_W     = 32,
  parameter int unsigned PULSE_W   = 100,
  parameter int unsigned DIR_SETUP = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEPS_W-1:0]      cmd_steps,
  input  logic [CNT_W-1:0]        cfg_start_period,
  input  logic [CNT_W-1:0]        cfg_min_period,
  input  logic [CNT_W-1:0]        cfg_accel,
  input  logic                    abort,
  input  logic                    estop,
`ifdef STEPPER_LIMIT_EN
  input  logic                    lim_fwd_n,
  input  logic                    lim_rev_n,
`endif
  output logic                    motor_enable,
  output logic                    motor_dir,
  output logic                    motor_step,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [STEPS_W-1:0]      steps_done,
  output logic signed [POS_W-1:0] position
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCEL, S_CRUISE, S_DECEL} state_t;

  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(2 * PULSE_W);
  localparam logic [CNT_W-1:0] PULSE_C    = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);

  state_t               r_state, w_state_n, w_phase;
  logic [CNT_W-1:0]     r_cnt, r_per, r_cur, r_min, r_start, r_accel;
  logic [CNT_W-1:0]     w_cnt_n, w_per_n, w_cur_n, w_min_n, w_start_n, w_accel_n, w_p;
  logic [STEPS_W-1:0]   r_rem, r_ramp, r_steps, w_rem_n, w_ramp_n, w_steps_n;
  logic [POS_W-1:0]     r_pos, w_pos_n;
  logic                 r_dir, r_en, r_step, r_busy, r_done, r_err, r_ready;
  logic                 w_dir_n, w_en_n, w_step_n, w_busy_n, w_done_n, w_err_n, w_ready_n;
  logic                 w_rise, w_lim_cmd, w_lim_run;
  logic [CNT_W-1:0]     w_cfg_min, w_cfg_start;
  logic [CNT_W:0]       w_sub, w_add;

  assign w_cfg_min   = (cfg_min_period > MIN_P) ? cfg_min_period : MIN_P;
  assign w_cfg_start = (cfg_start_period > w_cfg_min) ? cfg_start_period : w_cfg_min;
  assign w_sub       = {1'b0, r_cur} - {1'b0, r_accel};
  assign w_add       = {1'b0, r_cur} + {1'b0, r_accel};

`ifdef STEPPER_LIMIT_EN
  logic [1:0] r_fwd_sync, r_rev_sync;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fwd_sync <= 2'b11;
      r_rev_sync <= 2'b11;
    end else begin
      r_fwd_sync <= {r_fwd_sync[0], lim_fwd_n};
      r_rev_sync <= {r_rev_sync[0], lim_rev_n};
    end
  end
  assign w_lim_cmd = cmd_dir ? ~r_rev_sync[1] : ~r_fwd_sync[1];
  assign w_lim_run = r_dir   ? ~r_rev_sync[1] : ~r_fwd_sync[1];
`else
  assign w_lim_cmd = 1'b0;
  assign w_lim_run = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_per_n   = r_per;
    w_cur_n   = r_cur;
    w_min_n   = r_min;
    w_start_n = r_start;
    w_accel_n = r_accel;
    w_rem_n   = r_rem;
    w_ramp_n  = r_ramp;
    w_steps_n = r_steps;
    w_pos_n   = r_pos;
    w_dir_n   = r_dir;
    w_en_n    = r_en;
    w_step_n  = r_step;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_err_n   = r_err;
    w_rise    = 1'b0;
    w_phase   = r_state;
    w_p       = r_cur;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && !estop) begin
          w_steps_n = '0;
          w_err_n   = 1'b0;
          w_min_n   = w_cfg_min;
          w_start_n = w_cfg_start;
          w_accel_n = cfg_accel;
          w_cur_n   = w_cfg_start;
          w_ramp_n  = '0;
          w_rem_n   = cmd_steps;
          w_cnt_n   = '0;
          if (cmd_steps == '0 || w_lim_cmd) begin
            w_done_n = 1'b1;
            w_err_n  = w_lim_cmd;
          end else begin
            w_state_n = S_SETUP;
            w_busy_n  = 1'b1;
            w_en_n    = 1'b0;
            w_dir_n   = cmd_dir;
          end
        end
      end
      S_SETUP: begin
        if (abort) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_en_n    = 1'b1;
          w_step_n  = 1'b0;
        end else if (r_cnt == SETUP_LAST) begin
          w_rise  = 1'b1;
          w_phase = (r_accel == '0 || r_start == r_min) ? S_CRUISE : S_ACCEL;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        if (r_cnt == r_per - 1'b1) begin
          if (r_rem == '0) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
            w_en_n    = 1'b1;
            w_step_n  = 1'b0;
          end else begin
            w_rise = 1'b1;
          end
        end else begin
          w_cnt_n  = r_cnt + 1'b1;
          w_step_n = (w_cnt_n < PULSE_C);
        end
      end
    endcase

    // r_cur holds the next accel period; decel pre-increments so the ramp mirrors itself
    if (w_rise) begin
      w_cnt_n   = '0;
      w_step_n  = 1'b1;
      w_rem_n   = r_rem - 1'b1;
      w_steps_n = r_steps + 1'b1;
      w_pos_n   = r_dir ? r_pos - 1'b1 : r_pos + 1'b1;
      w_state_n = w_phase;
      case (w_phase)
        S_ACCEL: begin
          w_p      = r_cur;
          w_cur_n  = (w_sub[CNT_W] || w_sub[CNT_W-1:0] < r_min) ? r_min : w_sub[CNT_W-1:0];
          w_ramp_n = r_ramp + 1'b1;
          if (w_cur_n == r_min) w_state_n = S_CRUISE;
        end
        S_DECEL: begin
          w_p     = (w_add > {1'b0, r_start}) ? r_start : w_add[CNT_W-1:0];
          w_cur_n = w_p;
          if (r_ramp != '0) w_ramp_n = r_ramp - 1'b1;
        end
        default: w_p = r_cur;
      endcase
      w_per_n = w_p;
      if (w_phase != S_DECEL && w_rem_n <= w_ramp_n) w_state_n = S_DECEL;
    end

    if (abort && (r_state == S_ACCEL || r_state == S_CRUISE) && w_state_n != S_IDLE) begin
      w_state_n = S_DECEL;
      if (w_rem_n > w_ramp_n) w_rem_n = w_ramp_n;
    end

    if (r_state != S_IDLE && (estop || w_lim_run)) begin
      w_state_n = S_IDLE;
      w_done_n  = 1'b1;
      w_busy_n  = 1'b0;
      w_en_n    = 1'b1;
      w_step_n  = 1'b0;
      w_err_n   = 1'b1;
    end else if (r_state == S_IDLE && estop) begin
      w_err_n = 1'b1;
    end

    w_ready_n = (w_state_n == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_per   <= '0;
      r_cur   <= '0;
      r_min   <= '0;
      r_start <= '0;
      r_accel <= '0;
      r_rem   <= '0;
      r_ramp  <= '0;
      r_steps <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_en    <= 1'b1;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_per   <= w_per_n;
      r_cur   <= w_cur_n;
      r_min   <= w_min_n;
      r_start <= w_start_n;
      r_accel <= w_accel_n;
      r_rem   <= w_rem_n;
      r_ramp  <= w_ramp_n;
      r_steps <= w_steps_n;
      r_pos   <= w_pos_n;
      r_dir   <= w_dir_n;
      r_en    <= w_en_n;
      r_step  <= w_step_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_ready <= w_ready_n;
    end
  end

  assign cmd_ready    = r_ready;
  assign motor_enable = r_en;
  assign motor_dir    = r_dir;
  assign motor_step   = r_step;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign steps_done   = r_steps;
  assign position     = r_pos;

endmodule

// File: tb/tb_stepper_ramp_axis.sv
// Scoreboard bench for stepper_ramp_axis: stimulus queues expected step edges and done pulses.
module tb_stepper_ramp_axis;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [23:0] cmd_steps = '0;
  logic [15:0] cfg_start_period = '0;
  logic [15:0] cfg_min_period = '0;
  logic [15:0] cfg_accel = '0;
  logic        abort = 1'b0;
  logic        estop = 1'b0;
  logic        motor_enable, motor_dir, motor_step, busy, done, err;
  logic [23:0] steps_done;
  logic [31:0] position;
`ifdef STEPPER_LIMIT_EN
  logic        lim_fwd_n = 1'b1;
  logic        lim_rev_n = 1'b1;
`endif

  stepper_ramp_axis #(
    .CNT_W(16), .STEPS_W(24), .POS_W(32), .PULSE_W(100), .DIR_SETUP(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cfg_start_period(cfg_start_period),
    .cfg_min_period(cfg_min_period), .cfg_accel(cfg_accel), .abort(abort), .estop(estop),
`ifdef STEPPER_LIMIT_EN
    .lim_fwd_n(lim_fwd_n), .lim_rev_n(lim_rev_n),
`endif
    .motor_enable(motor_enable), .motor_dir(motor_dir), .motor_step(motor_step),
    .busy(busy), .done(done), .err(err), .steps_done(steps_done), .position(position)
  );

  always #10 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    longint      at;
    logic        e;
    logic [23:0] sd;
    logic [31:0] pos;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          per_tab[128];
  logic [31:0] exp_pos = '0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input longint at, input logic e,
                                  input logic [23:0] sd, input logic [31:0] pos);
    ev_t ev;
    ev.kind = kind; ev.at = at; ev.e = e; ev.sd = sd; ev.pos = pos;
    exp_q.push_back(ev);
  endfunction

  // rise/fall pairs for n steps from per_tab; t_end is when the move's done pulse is due
  task automatic push_steps(input longint r0, input int n, output longint t_end);
    longint t = r0;
    for (int i = 0; i < n; i++) begin
      push_ev(K_RISE, t, 1'b0, '0, '0);
      push_ev(K_FALL, t + 100, 1'b0, '0, '0);
      t += per_tab[i];
    end
    t_end = t;
  endtask

  task automatic observe(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      ev = exp_q.pop_front();
      chk("event_kind", kind, ev.kind);
      chk("event_cycle", cyc, ev.at);
      if (kind == K_DONE && ev.kind == K_DONE) begin
        chk("done_err", err, ev.e);
        chk("done_steps", steps_done, ev.sd);
        chk("done_position", position, ev.pos);
      end
    end
  endtask

  logic prev_step = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_step = 1'b0;
    end else begin
      if (!motor_step && prev_step) observe(K_FALL);
      if (motor_step && !prev_step) observe(K_RISE);
      if (done) observe(K_DONE);
      prev_step = motor_step;
    end
  end

  task automatic issue(input logic dir, input int steps, input int st, input int mn,
                       input int ac, output longint a);
    @(negedge clk);
    cmd_dir          = dir;
    cmd_steps        = 24'(steps);
    cfg_start_period = 16'(st);
    cfg_min_period   = 16'(mn);
    cfg_accel        = 16'(ac);
    cmd_valid        = 1'b1;
    a = cyc + 1;
  endtask

  task automatic release_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain(input longint limit);
    longint t0 = cyc;
    while (exp_q.size() != 0 && cyc - t0 < limit) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding events, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    longint a, t, r10;

    repeat (3) @(negedge clk);
    chk("rst_enable", motor_enable, 1);
    chk("rst_dir", motor_dir, 0);
    chk("rst_step", motor_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_steps", steps_done, 0);
    chk("rst_position", position, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reverse 5 steps at constant 300
    for (int i = 0; i < 5; i++) per_tab[i] = 300;
    issue(1'b1, 5, 300, 300, 0, a);
    push_steps(a + 50, 5, t);
    exp_pos = exp_pos - 32'd5;
    push_ev(K_DONE, t, 1'b0, 24'd5, exp_pos);
    release_cmd();
    wait_drain(3000);
    chk("rev5_position", position, 32'hFFFF_FFFB);

    // forward 10 at constant 1000, config disturbed mid-move
    for (int i = 0; i < 10; i++) per_tab[i] = 1000;
    issue(1'b0, 10, 1000, 1000, 0, a);
    push_steps(a + 50, 10, t);
    exp_pos = exp_pos + 32'd10;
    push_ev(K_DONE, t, 1'b0, 24'd10, exp_pos);
    release_cmd();
    cfg_start_period = 16'd300;
    cfg_min_period   = 16'd200;
    cfg_accel        = 16'd50;
    wait_until(a + 10);
    chk("move_busy", busy, 1);
    chk("move_enable", motor_enable, 0);
    chk("move_ready", cmd_ready, 0);
    chk("move_dir", motor_dir, 0);
    wait_drain(12000);

    // 100 steps: 1000..500 ramp, cruise 400, mirrored decel
    for (int i = 0; i < 100; i++)
      per_tab[i] = (i < 6) ? 1000 - 100 * i : (i < 94) ? 400 : 500 + 100 * (i - 94);
    issue(1'b0, 100, 1000, 400, 100, a);
    push_steps(a + 50, 100, t);
    exp_pos = exp_pos + 32'd100;
    push_ev(K_DONE, t, 1'b0, 24'd100, exp_pos);
    release_cmd();
    wait_drain(50000);

    // triangular 4-step profile
    per_tab[0] = 1000; per_tab[1] = 900; per_tab[2] = 900; per_tab[3] = 1000;
    issue(1'b0, 4, 1000, 400, 100, a);
    push_steps(a + 50, 4, t);
    exp_pos = exp_pos + 32'd4;
    push_ev(K_DONE, t, 1'b0, 24'd4, exp_pos);
    release_cmd();
    wait_drain(5000);

    // abort in cruise after the 10th step: 6 decel steps follow
    for (int i = 0; i < 16; i++)
      per_tab[i] = (i < 6) ? 1000 - 100 * i : (i < 10) ? 400 : 500 + 100 * (i - 10);
    issue(1'b0, 100, 1000, 400, 100, a);
    push_steps(a + 50, 16, t);
    exp_pos = exp_pos + 32'd16;
    push_ev(K_DONE, t, 1'b0, 24'd16, exp_pos);
    release_cmd();
    r10 = a + 50;
    for (int i = 0; i < 9; i++) r10 += per_tab[i];
    wait_until(r10 + 150);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain(12000);

    // abort during setup: done, no pulses
    issue(1'b0, 5, 1000, 1000, 0, a);
    release_cmd();
    wait_until(a + 10);
    abort = 1'b1;
    push_ev(K_DONE, a + 11, 1'b0, 24'd0, exp_pos);
    @(negedge clk);
    abort = 1'b0;
    wait_drain(100);

    // estop mid-pulse of step 2; zero config clamps the period to 200
    issue(1'b0, 10, 0, 0, 0, a);
    push_ev(K_RISE, a + 50, 1'b0, '0, '0);
    push_ev(K_FALL, a + 150, 1'b0, '0, '0);
    push_ev(K_RISE, a + 250, 1'b0, '0, '0);
    release_cmd();
    wait_until(a + 280);
    estop = 1'b1;
    exp_pos = exp_pos + 32'd2;
    push_ev(K_FALL, a + 281, 1'b0, '0, '0);
    push_ev(K_DONE, a + 281, 1'b1, 24'd2, exp_pos);
    @(negedge clk);
    estop = 1'b0;
    chk("estop_ready", cmd_ready, 1);
    chk("estop_busy", busy, 0);
    chk("estop_enable", motor_enable, 1);
    chk("estop_step", motor_step, 0);
    chk("estop_err", err, 1);
    wait_drain(100);

    // zero-step move: done one cycle after accept, err cleared
    issue(1'b0, 0, 1000, 1000, 0, a);
    push_ev(K_DONE, a, 1'b0, 24'd0, exp_pos);
    release_cmd();
    wait_drain(100);

    // estop in idle with a command present: err set, command dropped
    @(negedge clk);
    estop = 1'b1;
    cmd_valid = 1'b1;
    cmd_steps = 24'd3;
    @(negedge clk);
    estop = 1'b0;
    cmd_valid = 1'b0;
    chk("idle_estop_err", err, 1);
    chk("idle_estop_busy", busy, 0);
    chk("idle_estop_ready", cmd_ready, 1);
    repeat (100) @(negedge clk);
    chk("idle_estop_position", position, exp_pos);

    issue(1'b0, 0, 1000, 1000, 0, a);
    push_ev(K_DONE, a, 1'b0, 24'd0, exp_pos);
    release_cmd();
    wait_drain(100);

`ifdef STEPPER_LIMIT_EN
    lim_fwd_n = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 3, 1000, 1000, 0, a);
    push_ev(K_DONE, a, 1'b1, 24'd0, exp_pos);
    release_cmd();
    wait_drain(100);
    lim_fwd_n = 1'b1;
    repeat (4) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
